// File: rtl/led_reg_writer.sv
// Write-side sequencer for an enabled LED register: issues reps+1 one-cycle
// writes of an animated pattern spaced by a programmable gap, then pulses done.
module led_reg_writer #(
  parameter int WIDTH = 4,
  parameter int GAP_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic [GAP_W-1:0] gap,
  input  logic [3:0]       reps,
  output logic             busy,
  output logic             done,
  output logic             reg_en,
  output logic [WIDTH-1:0] reg_d
);

  // state | meaning
  // IDLE  | waiting for start; parameters latched when it is accepted
  // WRITE | reg_en high for one cycle with the current pattern value
  // WAIT  | gap counter counting down between consecutive writes
  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_WAIT} state_t;

  state_t           state, state_nxt;
  logic [1:0]       mode_q, mode_nxt;
  logic [GAP_W-1:0] gap_q, gap_nxt;
  logic [3:0]       reps_q, reps_nxt;
  logic [GAP_W-1:0] gap_cnt, gap_cnt_nxt;
  logic [3:0]       wr_cnt, wr_cnt_nxt;
  logic             busy_nxt, done_nxt, en_nxt;
  logic [WIDTH-1:0] d_nxt;
  logic             last_wr;

  assign last_wr = (wr_cnt == reps_q);

  function automatic logic [WIDTH-1:0] first_pat(input logic [1:0] m);
    case (m)
      2'b00:   first_pat = '0;
      2'b01:   first_pat = {{(WIDTH-1){1'b0}}, 1'b1};
      default: first_pat = '1;
    endcase
  endfunction

  // Each write value is derived from the previous one held on reg_d.
  function automatic logic [WIDTH-1:0] step_pat(input logic [1:0] m,
                                                input logic [WIDTH-1:0] d);
    case (m)
      2'b00:   step_pat = d + {{(WIDTH-1){1'b0}}, 1'b1};
      2'b01:   step_pat = {d[WIDTH-2:0], d[WIDTH-1]};
      2'b10:   step_pat = ~d;
      default: step_pat = d - {{(WIDTH-1){1'b0}}, 1'b1};
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      mode_q  <= '0;
      gap_q   <= '0;
      reps_q  <= '0;
      gap_cnt <= '0;
      wr_cnt  <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      reg_en  <= 1'b0;
      reg_d   <= '0;
    end else begin
      state   <= state_nxt;
      mode_q  <= mode_nxt;
      gap_q   <= gap_nxt;
      reps_q  <= reps_nxt;
      gap_cnt <= gap_cnt_nxt;
      wr_cnt  <= wr_cnt_nxt;
      busy    <= busy_nxt;
      done    <= done_nxt;
      reg_en  <= en_nxt;
      reg_d   <= d_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_WRITE;
      S_WRITE: begin
        if (last_wr)         state_nxt = S_IDLE;
        else if (gap_q != 0) state_nxt = S_WAIT;
        else                 state_nxt = S_WRITE;
      end
      S_WAIT:  if (gap_cnt == GAP_W'(1)) state_nxt = S_WRITE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    mode_nxt    = mode_q;
    gap_nxt     = gap_q;
    reps_nxt    = reps_q;
    gap_cnt_nxt = gap_cnt;
    wr_cnt_nxt  = wr_cnt;
    d_nxt       = reg_d;
    busy_nxt    = (state_nxt != S_IDLE);
    en_nxt      = (state_nxt == S_WRITE);
    done_nxt    = (state == S_WRITE) && last_wr;
    case (state)
      S_IDLE: begin
        if (start) begin
          mode_nxt   = mode;
          gap_nxt    = gap;
          reps_nxt   = reps;
          wr_cnt_nxt = '0;
          d_nxt      = first_pat(mode);
        end
      end
      S_WRITE: begin
        if (!last_wr) begin
          wr_cnt_nxt  = wr_cnt + 4'd1;
          gap_cnt_nxt = gap_q;
          if (gap_q == 0) d_nxt = step_pat(mode_q, reg_d);
        end
      end
      S_WAIT: begin
        gap_cnt_nxt = gap_cnt - GAP_W'(1);
        if (gap_cnt == GAP_W'(1)) d_nxt = step_pat(mode_q, reg_d);
      end
      default: ;
    endcase
  end

endmodule
